dsi_hs_lane_fsm: RTL and testbench
==================================

# dsi_hs_lane_fsm

Per-lane DSI high-speed transmit sequencer. It accepts a byte stream packet over a valid/ready handshake and wraps it in the D-PHY start-of-transmission and end-of-transmission sequence: LP-11, LP-01, LP-00, HS-zero, sync byte 0xB8, payload, HS-trail, then back to LP-11. It sits directly upstream of the lane's 8:1 OSERDES serializer pair. `hs_byte` feeds the serializer parallel data input and `hs_tz` feeds its 3-state control. One instance is used per data lane, all in the serializer's logic (divided) clock domain.

## Interface
Parameters (all in `clk` cycles; legal range 1..255; 8-bit down-counter):
- `T_LPX`, default 4: LP-01 duration.
- `T_HS_PREPARE`, default 4: LP-00 duration.
- `T_HS_ZERO`, default 8: HS-0 byte count before sync.
- `T_HS_TRAIL`, default 6: trail byte count.
- `T_HS_EXIT`, default 6: minimum LP-11 time after trail before next SoT.

Ports:
- `clk` in 1: byte clock; same clock as the serializer's logic clock.
- `rst` in 1: reset, asynchronous, active-high.
- `s_tdata` in 8: payload byte. Bit 0 is the first bit on the wire.
- `s_tvalid` in 1: payload valid; must stay high from packet start until the `s_tlast` beat.
- `s_tlast` in 1: marks the final payload byte.
- `s_tready` out 1: payload accept.
- `hs_byte` out 8: byte to the serializer.
- `hs_tz` out 1: HS 3-state control; 1 = HS driver high-Z.
- `lp_p` out 1: LP line level, P side.
- `lp_n` out 1: LP line level, N side.
- `lp_oe` out 1: LP driver enable.
- `busy` out 1: high in every state except IDLE.
- `underrun` out 1: sticky error; cleared at the next SoT.

## Operation
- `hs_byte`, `hs_tz`, `lp_*` and `busy` are registered. Each is a pure function of the state register plus the `hs_byte` load. Values listed per state are the values present while in that state.
- `s_tready` is combinational: high in SYNC, and high in DATA when `last_seen` = 0. It is 0 in all other states.
- A beat is accepted when `s_tvalid && s_tready` at a rising edge.

States (counter loaded with `param-1` on entry; leave when the counter reaches 0):
- **IDLE**: LP-11, `lp_oe`=1, `hs_tz`=1, `hs_byte`=0x00. Go to LPX when `s_tvalid`=1.
- **LPX**: LP-01 (`lp_p`=0, `lp_n`=1). Lasts `T_LPX` cycles. On entry clear `underrun`.
- **PREP**: LP-00. Lasts `T_HS_PREPARE` cycles.
- **ZERO**: `lp_oe`=0, `lp_p`/`lp_n`=0, `hs_tz`=0, `hs_byte`=0x00. Lasts `T_HS_ZERO` cycles.
- **SYNC**: `hs_byte`=0xB8. Lasts 1 cycle. Accepts the first payload beat.
- **DATA**: `hs_byte` holds the most recently accepted beat.
  - Each accepted beat at an edge appears on `hs_byte` for the next cycle.
  - Accepting the `s_tlast` beat sets `last_seen`.
  - When `last_seen`=1, the next edge goes to TRAIL.
- **TRAIL**: `hs_byte` = {8{~b}}, where b = bit 7 of the last byte driven before TRAIL (0xB8 counts, if the packet ends there). Lasts `T_HS_TRAIL` cycles. `hs_tz`=0.
- **EXIT**: LP-11, `lp_oe`=1, `hs_tz`=1, `hs_byte`=0x00. Lasts `T_HS_EXIT` cycles, then IDLE.
  - `s_tvalid` is ignored in EXIT.
  - SoT may start on the cycle right after the return to IDLE.

Boundary conditions:
- **Underrun**: `s_tvalid`=0 while `s_tready`=1 (in SYNC or DATA).
  - Set `underrun` and go to TRAIL at that edge. `hs_byte` is not updated.
  - Remaining beats of the aborted packet are not consumed by this block; upstream must flush them.
- **Single-beat packet**: `s_tlast` accepted in SYNC → DATA for one cycle showing that byte → TRAIL.
- **Reset**: asynchronous in any state, including mid-HS.
  - Immediately: state IDLE, LP-11, `lp_oe`=1, `hs_tz`=1, `hs_byte`=0x00, `busy`=0, `underrun`=0, `last_seen`=0.
  - The line returns to LP-11 with no trail; this is accepted behaviour.

## Timing
- Edge at which `s_tvalid` is seen in IDLE → first LP-01 cycle follows. Latency is 1 cycle.
- For N payload bytes, SoT to EXIT entry = T_LPX + T_HS_PREPARE + T_HS_ZERO + 1 + N + T_HS_TRAIL cycles.
- Back-to-back packets: minimum IDLE dwell is 1 cycle; minimum LP-11 time is T_HS_EXIT + 1 cycles.
- No combinational path from `s_tdata` to any output.

## Test plan
Use T_LPX=2, T_HS_PREPARE=3, T_HS_ZERO=4, T_HS_TRAIL=3, T_HS_EXIT=2 unless stated.

- **Reset values**: assert `rst` asynchronously between edges → `lp_p`/`lp_n`/`lp_oe`/`hs_tz`=1, `hs_byte`=0, `busy`=0, immediately (no clock edge needed).
- **3-byte packet**: 0x11, 0x22, 0x83 (`s_tlast` on 0x83). Required on consecutive cycles:
  - LP-01 ×2, then LP-00 ×3.
  - 0x00 ×4, 0xB8, 0x11, 0x22, 0x83.
  - 0x00 ×3 (trail, since bit 7 of 0x83 = 1).
  - LP-11 with `hs_tz`=1.
  - `s_tready` is high for exactly 3 cycles.
- **Single byte, trail polarity**: single byte 0x05 → `hs_byte` sequence …0xB8, 0x05, then 0xFF ×3; `underrun`=0.
- **Underrun**: drop `s_tvalid` after 2 of 5 bytes (0xAA, 0x55) → `underrun`=1. `hs_byte` shows 0x55, then 0xFF ×3, then LP-11. `underrun` stays 1 until the next LPX entry.
- **Mid-HS reset, then recovery**: `rst` pulse during DATA → outputs at reset values. The next packet produces a full correct sequence.
- **Back-to-back packets**: two packets with `s_tvalid` held high → between trail end and the next LP-01 there are exactly 3 LP-11 cycles (2 EXIT + 1 IDLE).

Source files
------------

// File: rtl/dsi_hs_lane_fsm.sv
// rtl/dsi_hs_lane_fsm.sv - per-lane DSI high-speed transmit sequencer (LP SoT, HS burst, trail, EXIT)
module dsi_hs_lane_fsm #(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 4,
    parameter int T_HS_ZERO    = 8,
    parameter int T_HS_TRAIL   = 6,
    parameter int T_HS_EXIT    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic [7:0] hs_byte,
    output logic       hs_tz,
    output logic       lp_p,
    output logic       lp_n,
    output logic       lp_oe,
    output logic       busy,
    output logic       underrun
);

    // Counter reload values: a phase of length T holds the counter for T cycles
    // by loading T-1 on entry and leaving once it reads zero.
    localparam logic [7:0] LPX_LD   = 8'(T_LPX - 1);
    localparam logic [7:0] PREP_LD  = 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] ZERO_LD  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] TRAIL_LD = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] EXIT_LD  = 8'(T_HS_EXIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LPX,
        S_PREP,
        S_ZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_EXIT
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       last_seen_q;
    logic [7:0] hs_byte_q;
    logic       hs_tz_q;
    logic       lp_p_q;
    logic       lp_n_q;
    logic       lp_oe_q;
    logic       busy_q;
    logic       underrun_q;
    logic       cnt_done;
    logic [7:0] trail_byte_d;

    assign cnt_done = (cnt_q == 8'd0);

    // Trail drives the complement of the final HS bit for the whole trail period.
    assign trail_byte_d = {8{~hs_byte_q[7]}};

    // Payload is accepted only in the sync slot and while the packet is still open.
    always_comb begin
        s_tready = (state_q == S_SYNC) || ((state_q == S_DATA) && !last_seen_q);
    end

    // Sequencer: state, phase counter and all line-facing outputs update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            last_seen_q <= 1'b0;
            hs_byte_q   <= 8'h00;
            hs_tz_q     <= 1'b1;
            lp_p_q      <= 1'b1;
            lp_n_q      <= 1'b1;
            lp_oe_q     <= 1'b1;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_tvalid) begin
                        state_q    <= S_LPX;
                        cnt_q      <= LPX_LD;
                        underrun_q <= 1'b0;
                        busy_q     <= 1'b1;
                        lp_p_q     <= 1'b0;
                        lp_n_q     <= 1'b1;
                    end
                end
                S_LPX: begin
                    if (cnt_done) begin
                        state_q <= S_PREP;
                        cnt_q   <= PREP_LD;
                        lp_n_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_PREP: begin
                    if (cnt_done) begin
                        state_q   <= S_ZERO;
                        cnt_q     <= ZERO_LD;
                        lp_oe_q   <= 1'b0;
                        hs_tz_q   <= 1'b0;
                        hs_byte_q <= 8'h00;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_ZERO: begin
                    if (cnt_done) begin
                        state_q   <= S_SYNC;
                        hs_byte_q <= SYNC_BYTE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_SYNC, S_DATA: begin
                    if ((state_q == S_DATA) && last_seen_q) begin
                        state_q     <= S_TRAIL;
                        cnt_q       <= TRAIL_LD;
                        hs_byte_q   <= trail_byte_d;
                        last_seen_q <= 1'b0;
                    end else if (s_tvalid) begin
                        state_q     <= S_DATA;
                        hs_byte_q   <= s_tdata;
                        last_seen_q <= s_tlast;
                    end else begin
                        // Upstream starved the lane: close the burst without the missing bytes.
                        state_q     <= S_TRAIL;
                        cnt_q       <= TRAIL_LD;
                        hs_byte_q   <= trail_byte_d;
                        last_seen_q <= 1'b0;
                        underrun_q  <= 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (cnt_done) begin
                        state_q   <= S_EXIT;
                        cnt_q     <= EXIT_LD;
                        hs_byte_q <= 8'h00;
                        hs_tz_q   <= 1'b1;
                        lp_oe_q   <= 1'b1;
                        lp_p_q    <= 1'b1;
                        lp_n_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_EXIT: begin
                    if (cnt_done) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hs_byte  = hs_byte_q;
    assign hs_tz    = hs_tz_q;
    assign lp_p     = lp_p_q;
    assign lp_n     = lp_n_q;
    assign lp_oe    = lp_oe_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_dsi_hs_lane_fsm.sv
// tb/tb_dsi_hs_lane_fsm.sv - scoreboard bench for dsi_hs_lane_fsm with randomized packets
module tb_dsi_hs_lane_fsm;

    localparam int P_LPX   = 2;
    localparam int P_PREP  = 3;
    localparam int P_ZERO  = 4;
    localparam int P_TRAIL = 3;
    localparam int P_EXIT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] hs_byte;
    logic       hs_tz;
    logic       lp_p;
    logic       lp_n;
    logic       lp_oe;
    logic       busy;
    logic       underrun;

    int n_checks = 0;
    int n_pass   = 0;

    // record layout: {busy, lp_p, lp_n, lp_oe, hs_tz, s_tready, underrun, hs_byte}
    logic [14:0] exp_q[$];
    logic [7:0]  pkt[$];
    bit          mon_en = 1'b0;
    int          lp11_run = 0;
    int          last_gap = -1;
    int          cyc = 0;

    dsi_hs_lane_fsm #(
        .T_LPX(P_LPX), .T_HS_PREPARE(P_PREP), .T_HS_ZERO(P_ZERO),
        .T_HS_TRAIL(P_TRAIL), .T_HS_EXIT(P_EXIT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .hs_byte(hs_byte), .hs_tz(hs_tz), .lp_p(lp_p), .lp_n(lp_n), .lp_oe(lp_oe),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] rec(input logic b, input logic pp, input logic pn,
                                        input logic oe, input logic tz, input logic rdy,
                                        input logic und, input logic [7:0] d);
        return {b, pp, pn, oe, tz, rdy, und, d};
    endfunction

    // Reference: the cycle-by-cycle line picture of one burst, straight from the protocol phases.
    task automatic model_packet(input int n_acc, input bit und);
        logic [7:0] last_b;
        for (int i = 0; i < P_LPX; i++)  exp_q.push_back(rec(1, 0, 1, 1, 1, 0, 0, 8'h00));
        for (int i = 0; i < P_PREP; i++) exp_q.push_back(rec(1, 0, 0, 1, 1, 0, 0, 8'h00));
        for (int i = 0; i < P_ZERO; i++) exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 8'h00));
        exp_q.push_back(rec(1, 0, 0, 0, 0, 1, 0, 8'hB8));
        for (int i = 0; i < n_acc; i++)
            exp_q.push_back(rec(1, 0, 0, 0, 0, (und || (i < n_acc - 1)) ? 1'b1 : 1'b0, 0, pkt[i]));
        last_b = (n_acc > 0) ? pkt[n_acc - 1] : 8'hB8;
        for (int i = 0; i < P_TRAIL; i++)
            exp_q.push_back(rec(1, 0, 0, 0, 0, 0, und, last_b[7] ? 8'h00 : 8'hFF));
        for (int i = 0; i < P_EXIT; i++) exp_q.push_back(rec(1, 1, 1, 1, 1, 0, und, 8'h00));
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Monitor: every busy cycle must match the next expected record.
    always @(negedge clk) begin
        cyc++;
        if (lp_oe && lp_p && lp_n) begin
            lp11_run++;
        end else begin
            if (lp_oe && !lp_p && lp_n && lp11_run > 0) last_gap = lp11_run;
            lp11_run = 0;
        end
        if (mon_en && !rst && busy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_busy_cycle_%0d: got busy with no expectation", cyc);
            end else begin
                logic [14:0] e;
                logic [14:0] a;
                e = exp_q.pop_front();
                a = {busy, lp_p, lp_n, lp_oe, hs_tz, s_tready, underrun, hs_byte};
                if (a == e) n_pass++;
                else $display("FAIL line_cycle_%0d: got %h want %h (busy,lp_p,lp_n,lp_oe,hs_tz,rdy,und,byte)",
                              cyc, a, e);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Drives pkt; und_after < n drops s_tvalid once that many beats were accepted.
    task automatic send_packet(input int n, input int und_after, input bit keep_valid,
                               input logic [7:0] next_first);
        bit ok;
        bit und;
        und = (und_after < n);
        model_packet(und ? und_after : n, und);
        s_tvalid = 1'b1;
        s_tdata  = pkt[0];
        s_tlast  = (n == 1);
        for (int i = 0; i < n; i++) begin
            if (i == und_after) begin
                wait_ready(ok);
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            s_tdata = pkt[i];
            s_tlast = (i == n - 1);
            wait_ready(ok);
            if (!ok) begin
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tlast = 1'b0;
        if (keep_valid) s_tdata = next_first;
        else s_tvalid = 1'b0;
    endtask

    initial begin
        int n;
        int u;
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = 8'h00;
        s_tlast = 1'b0;
        #3;
        check("rst_lp_p", lp_p, 1);
        check("rst_lp_n", lp_n, 1);
        check("rst_lp_oe", lp_oe, 1);
        check("rst_hs_tz", hs_tz, 1);
        check("rst_hs_byte", hs_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // three-byte packet
        pkt = '{8'h11, 8'h22, 8'h83};
        send_packet(3, 3, 1'b0, 8'h00);
        wait_idle();
        check("three_byte_underrun", underrun, 0);

        // single byte, trail polarity
        pkt = '{8'h05};
        send_packet(1, 1, 1'b0, 8'h00);
        wait_idle();
        check("single_underrun", underrun, 0);

        // underrun after two of five
        pkt = '{8'hAA, 8'h55, 8'h01, 8'h02, 8'h03};
        send_packet(5, 2, 1'b0, 8'h00);
        wait_idle();
        check("underrun_set", underrun, 1);
        repeat (4) @(posedge clk);
        #1;
        check("underrun_sticky", underrun, 1);

        // mid-HS reset then recovery
        mon_en = 1'b0;
        check("queue_drained_pre_reset", exp_q.size(), 0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = 8'h3C;
        s_tlast  = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        check("pre_reset_data", hs_byte, 8'h3C);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_lp", {lp_p, lp_n, lp_oe}, 3'b111);
        check("midrst_hs_tz", hs_tz, 1);
        check("midrst_hs_byte", hs_byte, 0);
        check("midrst_busy", busy, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_tready", s_tready, 0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        pkt = '{8'h7E, 8'hC1};
        send_packet(2, 2, 1'b0, 8'h00);
        wait_idle();

        // back-to-back with s_tvalid held
        pkt = '{8'h12, 8'h34};
        send_packet(2, 2, 1'b1, 8'h9C);
        pkt = '{8'h9C, 8'h40, 8'h21};
        send_packet(3, 3, 1'b0, 8'h00);
        wait_idle();
        check("b2b_lp11_gap", last_gap, P_EXIT + 1);

        // randomized packets
        for (int p = 0; p < 24; p++) begin
            n = $urandom_range(1, 6);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
            u = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : n;
            send_packet(n, u, 1'b0, 8'h00);
            wait_idle();
            check("rand_underrun", underrun, (u < n) ? 1 : 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
